// File: rtl/cpu_data_pkg.sv
// Shared CPU bus types: controller FSM states, address regions and the
// boundaries of the 16-bit address map.
package cpu_data;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_RAM = 2'd0,
    REG_ROM = 2'd1,
    REG_IO  = 2'd2
  } region_t;

  localparam logic [15:0] RAM_BASE = 16'h0000;
  localparam logic [15:0] RAM_END  = 16'h1FFF;
  localparam logic [15:0] ROM_BASE = 16'h2000;
  localparam logic [15:0] ROM_END  = 16'hDFFF;
  localparam logic [15:0] IO_BASE  = 16'hE000;

endpackage

// File: rtl/addr_decoder.sv
// Combinational address-map decoder: maps a CPU address onto its region.
module addr_decoder
  import cpu_data::*;
(
  input  logic [15:0] addr,
  output region_t     region
);

  always_comb begin
    region = REG_IO;
    if (addr <= RAM_END)
      region = REG_RAM;
    else if (addr <= ROM_END)
      region = REG_ROM;
  end

endmodule

// File: rtl/bus_controller.sv
// CPU-to-memory bus controller: decodes the address region, runs a
// wait-stated access and completes a ready handshake with the CPU.
module bus_controller
  import cpu_data::*;
#(
  parameter int RAM_WAIT = 0,
  parameter int ROM_WAIT = 1,
  parameter int IO_WAIT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] adress_bus,
  inout  wire  [7:0]  date_bus,
  input  logic        r,
  input  logic        w,
  output logic        ready,
  output logic        ram_cs,
  output logic        rom_cs,
  output logic        io_cs,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic        bus_error
);

  localparam int MAX_AB   = (RAM_WAIT > ROM_WAIT) ? RAM_WAIT : ROM_WAIT;
  localparam int MAX_WAIT = (MAX_AB > IO_WAIT) ? MAX_AB : IO_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  state_t           state;
  state_t           next_state;
  region_t          region;
  region_t          region_q;
  logic             write_q;
  logic [15:0]      addr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       rdata_q;
  logic [CNT_W-1:0] cnt;

  function automatic logic [CNT_W-1:0] wait_for(input region_t rg);
    case (rg)
      REG_RAM: wait_for = CNT_W'(RAM_WAIT);
      REG_ROM: wait_for = CNT_W'(ROM_WAIT);
      default: wait_for = CNT_W'(IO_WAIT);
    endcase
  endfunction

  addr_decoder u_decoder (
    .addr   (adress_bus),
    .region (region)
  );

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (r ^ w) next_state = ACCESS;
      ACCESS:  if (cnt == '0) next_state = HOLD;
      HOLD:    if (!r && !w) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Request latch and wait counter; strobes are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt       <= '0;
      region_q  <= REG_RAM;
      write_q   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      bus_error <= 1'b0;
      case (state)
        IDLE: begin
          if (r && w) begin
            bus_error <= 1'b1;
          end else if (r ^ w) begin
            addr_q   <= adress_bus;
            region_q <= region;
            write_q  <= w;
            cnt      <= wait_for(region);
            if (w) wdata_q <= date_bus;
            if (w && region == REG_ROM) bus_error <= 1'b1;
          end
        end
        ACCESS: if (cnt != '0) cnt <= cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Read byte captured on the last ACCESS cycle, presented during HOLD.
  always_ff @(posedge clk) begin
    if (state == ACCESS && cnt == '0 && !write_q)
      rdata_q <= mem_rdata;
  end

  always_comb begin
    ram_cs    = (state == ACCESS) && (region_q == REG_RAM);
    rom_cs    = (state == ACCESS) && (region_q == REG_ROM);
    io_cs     = (state == ACCESS) && (region_q == REG_IO);
    mem_we    = (state == ACCESS) && write_q && (region_q != REG_ROM);
    ready     = (state == HOLD);
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
  end

  assign date_bus = (state == HOLD && !write_q) ? rdata_q : 8'bz;

endmodule

// File: tb/tb_bus_controller.sv
// Scoreboard bench for bus_controller: directed transfers push expectations,
// a negedge monitor scores each transfer when ready rises.
module tb_bus_controller;
  import cpu_data::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] adress_bus;
  logic        r, w;
  logic        ready, ram_cs, rom_cs, io_cs, mem_we, bus_error;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  wire  [7:0]  date_bus;
  logic        drv_en;
  logic [7:0]  drv_val;

  assign date_bus = drv_en ? drv_val : 8'bz;

  bus_controller #(.RAM_WAIT(0), .ROM_WAIT(1), .IO_WAIT(2)) dut (
    .clk(clk), .reset(reset), .adress_bus(adress_bus), .date_bus(date_bus),
    .r(r), .w(w), .ready(ready), .ram_cs(ram_cs), .rom_cs(rom_cs),
    .io_cs(io_cs), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    string       name;
    int          start;
    int          ready_rel;
    int          ram_n, rom_n, io_n;
    int          we_n;
    int          err_n;
    bit          rd;
    logic [7:0]  data;
    logic [15:0] addr;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  function automatic void check(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  // Monitor: accumulate per-transfer activity, score it when ready rises.
  int   a_ram = 0, a_rom = 0, a_io = 0, a_we = 0, a_err = 0;
  int   a_first = 0, a_err_rel = 0, a_addr_bad = 0, a_wd_bad = 0;
  logic prev_ready = 1'b0;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      automatic int rel = cyc - sb[0].start;
      if (rel > 0) begin
        if (ram_cs) a_ram++;
        if (rom_cs) a_rom++;
        if (io_cs)  a_io++;
        if ((ram_cs || rom_cs || io_cs) && a_first == 0) a_first = rel;
        if ((ram_cs || rom_cs || io_cs) && mem_addr != sb[0].addr) a_addr_bad++;
        if (mem_we) begin
          a_we++;
          if (mem_wdata != sb[0].data) a_wd_bad++;
        end
        if (bus_error) begin
          a_err++;
          if (a_err_rel == 0) a_err_rel = rel;
        end
      end
      if (ready && !prev_ready) begin
        automatic exp_t e = sb.pop_front();
        check({e.name, " ready_cycle"}, rel, e.ready_rel);
        check({e.name, " ram_cs_cycles"}, a_ram, e.ram_n);
        check({e.name, " rom_cs_cycles"}, a_rom, e.rom_n);
        check({e.name, " io_cs_cycles"}, a_io, e.io_n);
        check({e.name, " first_cs_cycle"}, a_first, 1);
        check({e.name, " mem_we_cycles"}, a_we, e.we_n);
        check({e.name, " bus_error_pulses"}, a_err, e.err_n);
        if (e.err_n > 0) check({e.name, " bus_error_cycle"}, a_err_rel, 1);
        check({e.name, " mem_addr_unstable"}, a_addr_bad, 0);
        if (e.we_n > 0) check({e.name, " mem_wdata_bad"}, a_wd_bad, 0);
        if (e.rd) check({e.name, " date_bus"}, int'(date_bus), int'(e.data));
        a_ram = 0; a_rom = 0; a_io = 0; a_we = 0; a_err = 0;
        a_first = 0; a_err_rel = 0; a_addr_bad = 0; a_wd_bad = 0;
      end
    end
    prev_ready = ready;
  end

  // kind: 0 RAM, 1 ROM, 2 IO; wt is the hand-chosen wait count of that region.
  task automatic txn(string nm, logic [15:0] a, bit is_w, logic [7:0] d, int wt, int kind);
    exp_t e;
    bit   rom_w;
    rom_w = is_w && (kind == 1);
    @(negedge clk);
    adress_bus = a;
    r = !is_w;
    w = is_w;
    if (is_w) begin
      drv_en  = 1'b1;
      drv_val = d;
    end else begin
      mem_rdata = d;
    end
    e.name      = nm;
    e.start     = cyc;
    e.ready_rel = 2 + wt;
    e.ram_n     = (kind == 0) ? wt + 1 : 0;
    e.rom_n     = (kind == 1) ? wt + 1 : 0;
    e.io_n      = (kind == 2) ? wt + 1 : 0;
    e.we_n      = (is_w && !rom_w) ? wt + 1 : 0;
    e.err_n     = rom_w ? 1 : 0;
    e.rd        = !is_w;
    e.data      = d;
    e.addr      = a;
    sb.push_back(e);
    @(negedge clk);
    r = 1'b0;
    w = 1'b0;
    drv_en = 1'b0;
    drv_val = 8'h00;
    adress_bus = ~a;
    if (!is_w) mem_rdata = d;
    for (int i = 0; i < 30 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: ready not seen within 30 cycles", nm);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; r = 1'b0; w = 1'b0; adress_bus = 16'h0000;
    mem_rdata = 8'h00; drv_en = 1'b0; drv_val = 8'h00;
    repeat (3) @(negedge clk);
    check("reset ready", int'(ready), 0);
    check("reset cs", int'({ram_cs, rom_cs, io_cs}), 0);
    check("reset mem_we", int'(mem_we), 0);
    check("reset bus_error", int'(bus_error), 0);
    check("reset mem_addr", int'(mem_addr), 0);
    check("reset mem_wdata", int'(mem_wdata), 0);
    check("reset state", int'(dut.state), int'(IDLE));

    // Strobe presented while reset is still high must be ignored.
    adress_bus = 16'h0010; r = 1'b1;
    @(negedge clk);
    check("reset_prio ram_cs", int'(ram_cs), 0);
    check("reset_prio state", int'(dut.state), int'(IDLE));
    reset = 1'b0; r = 1'b0;
    @(negedge clk);

    txn("ram_read", 16'h0010, 1'b0, 8'hA5, 0, 0);
    txn("rom_read", 16'h2000, 1'b0, 8'h3C, 1, 1);
    txn("io_write", 16'hE001, 1'b1, 8'h5A, 2, 2);
    txn("rom_write", 16'h3000, 1'b1, 8'h77, 1, 1);

    // Both strobes high: error pulse, no select, FSM stays idle.
    @(negedge clk);
    adress_bus = 16'h0000; r = 1'b1; w = 1'b1;
    @(negedge clk);
    r = 1'b0; w = 1'b0;
    check("dual bus_error", int'(bus_error), 1);
    check("dual cs", int'({ram_cs, rom_cs, io_cs}), 0);
    check("dual state", int'(dut.state), int'(IDLE));
    @(negedge clk);
    check("dual bus_error_end", int'(bus_error), 0);
    check("dual cs_after", int'({ram_cs, rom_cs, io_cs}), 0);

    // Reset in cycle 2 of an IO read.
    @(negedge clk);
    adress_bus = 16'hE010; r = 1'b1; mem_rdata = 8'h99;
    @(negedge clk);
    r = 1'b0;
    check("midreset io_cs_before", int'(io_cs), 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midreset io_cs", int'(io_cs), 0);
    check("midreset ready", int'(ready), 0);
    check("midreset state", int'(dut.state), int'(IDLE));
    check("midreset mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    @(negedge clk);

    txn("ram_read_top", 16'h1FFF, 1'b0, 8'h0F, 0, 0);
    txn("rom_read_top", 16'hDFFF, 1'b0, 8'h42, 1, 1);
    txn("io_read_base", 16'hE000, 1'b0, 8'hC3, 2, 2);
    txn("ram_write", 16'h0100, 1'b1, 8'h81, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
